ex_stage: RTL and testbench

Execute stage of the 5-stage pipeline, directly downstream of the forwarding unit. It consumes forward_A/forward_B to pick ALU operands from the register file, the EX/MEM register, or the MEM/WB write-back value. It runs the ALU, including a multi-cycle iterative multiply, and owns the EX/MEM pipeline register. That register's Rd, Reg_write and valid fields feed back into the forwarding unit.

---
 rtl/pipe_pkg.sv | 31 +++
 rtl/ex_seq_mul.sv | 101 ++++++++++
 rtl/ex_stage.sv | 170 +++++++++++++++++
 tb/tb_ex_stage.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath/register widths, ALU opcodes,
// forwarding-select encodings, bubble polarity and the multiplier FSM states.
package pipe_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 3;
    localparam int CNT_W  = $clog2(DATA_W);

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_MUL = 4'd8;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_EXM = 2'b01;
    localparam logic [1:0] FWD_MWB = 2'b10;

    // Valid flags in this pipeline are bubble flags: 1 means "no instruction".
    localparam logic BUBBLE = 1'b1;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_RUN  = 1'b1
    } mul_state_e;

endpackage

// File: rtl/ex_seq_mul.sv
// Iterative shift-add multiplier, one partial-product step per clock.
//
// state    | meaning
// MUL_IDLE | waiting for start_i; operands are captured on the start edge
// MUL_RUN  | stepping; cnt_q counts steps 0..DATA_W-1, done on the last one
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   start_i      live MUL presented in EX (already qualified by flush)
//   abort_i      drop any multiply in progress (takes priority over freeze_i)
//   freeze_i     hold FSM, counter and datapath (downstream stall)
//   a_i, b_i     operands, sampled only on the start edge
//   busy_o       EX must hold its instruction and emit bubbles
//   done_o       product_o is final this cycle
//   product_o    low DATA_W bits of a*b (valid when done_o)
module ex_seq_mul
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              freeze_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] product_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    mul_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] step_sum;

    // The final step's sum is the product, so EX/MEM can load it on the same
    // edge that the FSM returns to idle.
    assign step_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign product_o = step_sum;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        busy_o   = 1'b0;
        done_o   = 1'b0;
        case (state_q)
            MUL_IDLE: begin
                busy_o = start_i && !abort_i;
                if (start_i && !abort_i && !freeze_i) begin
                    state_d  = MUL_RUN;
                    cnt_d    = '0;
                    mcand_d  = a_i;
                    mplier_d = b_i;
                    acc_d    = '0;
                end
            end
            MUL_RUN: begin
                busy_o = (cnt_q != CNT_LAST);
                done_o = (cnt_q == CNT_LAST);
                if (abort_i) begin
                    state_d = MUL_IDLE;
                    cnt_d   = '0;
                end else if (!freeze_i) begin
                    acc_d    = step_sum;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = MUL_IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = MUL_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MUL_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding mux, ALU, iterative multiplier and the
// EX/MEM pipeline register.
//
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   EX_*                                ID/EX register contents (EX_valid=1 is a bubble)
//   forward_A, forward_B                operand source select from the forwarding unit
//   MWB_wb_data                         MEM/WB write-back value
//   stall_in                            MEM stall: hold EX/MEM and freeze the multiplier
//   flush                               kill the instruction in EX
//   ex_busy                             multiply in progress; upstream must hold
//   EXM_*                               EX/MEM register (EXM_valid=1 is a bubble)
module ex_stage
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              EX_valid,
    input  logic [REG_AW-1:0] EX_Reg_Rs,
    input  logic [REG_AW-1:0] EX_Reg_Rt,
    input  logic [REG_AW-1:0] EX_Reg_Rd,
    input  logic [DATA_W-1:0] EX_rs_data,
    input  logic [DATA_W-1:0] EX_rt_data,
    input  logic [DATA_W-1:0] EX_imm,
    input  logic [3:0]        EX_alu_op,
    input  logic              EX_use_imm,
    input  logic              EX_Reg_write,
    input  logic              EX_mem_read,
    input  logic              EX_mem_write,
    input  logic [1:0]        forward_A,
    input  logic [1:0]        forward_B,
    input  logic [DATA_W-1:0] MWB_wb_data,
    input  logic              stall_in,
    input  logic              flush,
    output logic              ex_busy,
    output logic              EXM_valid,
    output logic [REG_AW-1:0] EXM_Reg_Rd,
    output logic              EXM_Reg_write,
    output logic              EXM_mem_read,
    output logic              EXM_mem_write,
    output logic [DATA_W-1:0] EXM_alu_result,
    output logic [DATA_W-1:0] EXM_store_data
);

    logic [DATA_W-1:0] op_a, rt_fwd, op_b, alu_res;
    logic              live, mul_start, mul_busy, mul_done;
    logic [DATA_W-1:0] mul_product;
    logic              unused_rs_rt;

    logic              exm_valid_q, exm_valid_d;
    logic [REG_AW-1:0] exm_rd_q, exm_rd_d;
    logic              exm_rw_q, exm_rw_d;
    logic              exm_mr_q, exm_mr_d;
    logic              exm_mw_q, exm_mw_d;
    logic [DATA_W-1:0] exm_res_q, exm_res_d;
    logic [DATA_W-1:0] exm_sd_q, exm_sd_d;

    // Source addresses are only meaningful to the forwarding unit upstream.
    assign unused_rs_rt = ^{EX_Reg_Rs, EX_Reg_Rt};

    function automatic logic [DATA_W-1:0] fwd_sel(input logic [1:0] sel,
                                                  input logic [DATA_W-1:0] rf_val,
                                                  input logic [DATA_W-1:0] exm_val,
                                                  input logic [DATA_W-1:0] mwb_val);
        case (sel)
            FWD_REG: fwd_sel = rf_val;
            FWD_EXM: fwd_sel = exm_val;
            FWD_MWB: fwd_sel = mwb_val;
            default: fwd_sel = rf_val;
        endcase
    endfunction

    assign op_a   = fwd_sel(forward_A, EX_rs_data, exm_res_q, MWB_wb_data);
    assign rt_fwd = fwd_sel(forward_B, EX_rt_data, exm_res_q, MWB_wb_data);
    assign op_b   = EX_use_imm ? EX_imm : rt_fwd;

    always_comb begin
        alu_res = '0;
        case (EX_alu_op)
            ALU_ADD: alu_res = op_a + op_b;
            ALU_SUB: alu_res = op_a - op_b;
            ALU_AND: alu_res = op_a & op_b;
            ALU_OR:  alu_res = op_a | op_b;
            ALU_XOR: alu_res = op_a ^ op_b;
            ALU_SLL: alu_res = op_a << op_b[3:0];
            ALU_SRL: alu_res = op_a >> op_b[3:0];
            ALU_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_MUL: alu_res = '0;  // product comes from ex_seq_mul
            default: alu_res = '0;
        endcase
    end

    assign live      = (EX_valid != BUBBLE);
    assign mul_start = live && (EX_alu_op == ALU_MUL) && !flush;

    // Operands are captured at start: EX/MEM turns to bubbles while running,
    // so an EXM-forwarded operand would otherwise change mid-multiply.
    ex_seq_mul u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (mul_start),
        .abort_i   (flush),
        .freeze_i  (stall_in),
        .a_i       (op_a),
        .b_i       (op_b),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    assign ex_busy = mul_busy;

    always_comb begin
        exm_valid_d = exm_valid_q;
        exm_rd_d    = exm_rd_q;
        exm_rw_d    = exm_rw_q;
        exm_mr_d    = exm_mr_q;
        exm_mw_d    = exm_mw_q;
        exm_res_d   = exm_res_q;
        exm_sd_d    = exm_sd_q;
        if (!stall_in) begin
            if (flush || mul_busy || !live) begin
                exm_valid_d = BUBBLE;
                exm_rd_d    = '0;
                exm_rw_d    = 1'b0;
                exm_mr_d    = 1'b0;
                exm_mw_d    = 1'b0;
                exm_res_d   = '0;
                exm_sd_d    = '0;
            end else begin
                exm_valid_d = ~BUBBLE;
                exm_rd_d    = EX_Reg_Rd;
                exm_rw_d    = EX_Reg_write;
                exm_mr_d    = EX_mem_read;
                exm_mw_d    = EX_mem_write;
                exm_res_d   = mul_done ? mul_product : alu_res;
                exm_sd_d    = rt_fwd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exm_valid_q <= BUBBLE;
            exm_rd_q    <= '0;
            exm_rw_q    <= 1'b0;
            exm_mr_q    <= 1'b0;
            exm_mw_q    <= 1'b0;
            exm_res_q   <= '0;
            exm_sd_q    <= '0;
        end else begin
            exm_valid_q <= exm_valid_d;
            exm_rd_q    <= exm_rd_d;
            exm_rw_q    <= exm_rw_d;
            exm_mr_q    <= exm_mr_d;
            exm_mw_q    <= exm_mw_d;
            exm_res_q   <= exm_res_d;
            exm_sd_q    <= exm_sd_d;
        end
    end

    assign EXM_valid      = exm_valid_q;
    assign EXM_Reg_Rd     = exm_rd_q;
    assign EXM_Reg_write  = exm_rw_q;
    assign EXM_mem_read   = exm_mr_q;
    assign EXM_mem_write  = exm_mw_q;
    assign EXM_alu_result = exm_res_q;
    assign EXM_store_data = exm_sd_q;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed scenarios followed by a randomized instruction
// stream compared against an arithmetic reference of the EX/MEM register.
module tb_ex_stage;
    import pipe_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              EX_valid;
    logic [REG_AW-1:0] EX_Reg_Rs, EX_Reg_Rt, EX_Reg_Rd;
    logic [DATA_W-1:0] EX_rs_data, EX_rt_data, EX_imm;
    logic [3:0]        EX_alu_op;
    logic              EX_use_imm, EX_Reg_write, EX_mem_read, EX_mem_write;
    logic [1:0]        forward_A, forward_B;
    logic [DATA_W-1:0] MWB_wb_data;
    logic              stall_in, flush;
    logic              ex_busy, EXM_valid, EXM_Reg_write, EXM_mem_read, EXM_mem_write;
    logic [REG_AW-1:0] EXM_Reg_Rd;
    logic [DATA_W-1:0] EXM_alu_result, EXM_store_data;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .rst_n(rst_n), .EX_valid(EX_valid),
        .EX_Reg_Rs(EX_Reg_Rs), .EX_Reg_Rt(EX_Reg_Rt), .EX_Reg_Rd(EX_Reg_Rd),
        .EX_rs_data(EX_rs_data), .EX_rt_data(EX_rt_data), .EX_imm(EX_imm),
        .EX_alu_op(EX_alu_op), .EX_use_imm(EX_use_imm), .EX_Reg_write(EX_Reg_write),
        .EX_mem_read(EX_mem_read), .EX_mem_write(EX_mem_write),
        .forward_A(forward_A), .forward_B(forward_B), .MWB_wb_data(MWB_wb_data),
        .stall_in(stall_in), .flush(flush), .ex_busy(ex_busy),
        .EXM_valid(EXM_valid), .EXM_Reg_Rd(EXM_Reg_Rd), .EXM_Reg_write(EXM_Reg_write),
        .EXM_mem_read(EXM_mem_read), .EXM_mem_write(EXM_mem_write),
        .EXM_alu_result(EXM_alu_result), .EXM_store_data(EXM_store_data)
    );

    int total = 0;
    int bad   = 0;

    // Reference copy of the EX/MEM register.
    logic              m_valid, m_rw, m_mr, m_mw;
    logic [REG_AW-1:0] m_rd;
    logic [DATA_W-1:0] m_res, m_sd;
    bit                m_known;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] alu_ref(input int op, input int a, input int b);
        longint r;
        int sa, sb;
        case (op)
            0: r = a + b;
            1: r = a - b;
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = longint'(a) << (b % 16);
            6: r = a >> (b % 16);
            7: begin
                sa = (a >= 32768) ? a - 65536 : a;
                sb = (b >= 32768) ? b - 65536 : b;
                r  = (sa < sb) ? 1 : 0;
            end
            8: r = longint'(a) * longint'(b);
            default: r = 0;
        endcase
        return r[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] fwd_ref(input logic [1:0] sel, input logic [DATA_W-1:0] rf);
        if (sel == 2'b01) return m_res;
        if (sel == 2'b10) return MWB_wb_data;
        return rf;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic bub, input logic [3:0] op, input logic [15:0] rs,
                         input logic [15:0] rt, input logic [15:0] imm, input logic ui,
                         input logic [1:0] fa, input logic [1:0] fb, input logic [2:0] rd,
                         input logic rw, input logic mr, input logic mw);
        EX_valid = bub; EX_alu_op = op; EX_rs_data = rs; EX_rt_data = rt; EX_imm = imm;
        EX_use_imm = ui; forward_A = fa; forward_B = fb; EX_Reg_Rd = rd;
        EX_Reg_Rs = 3'(rd + 1); EX_Reg_Rt = 3'(rd + 2);
        EX_Reg_write = rw; EX_mem_read = mr; EX_mem_write = mw;
    endtask

    // Expected EX/MEM contents after the coming edge, for non-multiply cycles.
    task automatic model_edge();
        logic [DATA_W-1:0] a, b, rtv;
        if (stall_in) return;
        if (flush || EX_valid) begin
            m_valid = 1'b1; m_rw = 1'b0; m_mr = 1'b0; m_mw = 1'b0; m_known = 0;
        end else begin
            a   = fwd_ref(forward_A, EX_rs_data);
            rtv = fwd_ref(forward_B, EX_rt_data);
            b   = EX_use_imm ? EX_imm : rtv;
            m_res = alu_ref(int'(EX_alu_op), int'(a), int'(b));
            m_sd = rtv; m_rd = EX_Reg_Rd; m_rw = EX_Reg_write;
            m_mr = EX_mem_read; m_mw = EX_mem_write; m_valid = 1'b0; m_known = 1;
        end
    endtask

    task automatic check_exm(input string tag);
        chk({tag, "_valid"}, 16'(EXM_valid), 16'(m_valid));
        chk({tag, "_rw"}, 16'(EXM_Reg_write), 16'(m_rw));
        chk({tag, "_mr"}, 16'(EXM_mem_read), 16'(m_mr));
        chk({tag, "_mw"}, 16'(EXM_mem_write), 16'(m_mw));
        if (!m_valid) begin
            chk({tag, "_rd"}, 16'(EXM_Reg_Rd), 16'(m_rd));
            chk({tag, "_res"}, EXM_alu_result, m_res);
            chk({tag, "_sd"}, EXM_store_data, m_sd);
        end
    endtask

    // MUL already presented with forward_B=00; runs DATA_W+1 cycles unstalled.
    task automatic mul_seq(input string tag, input logic [DATA_W-1:0] exp_p, input bit vary_mwb);
        int busy_n = 0;
        int bub_bad = 0;
        for (int e = 1; e <= DATA_W + 1; e++) begin
            if (vary_mwb && e > 1) MWB_wb_data = 16'($urandom);
            #1;
            if (ex_busy === 1'b1) busy_n++;
            if (e == DATA_W + 1) chk({tag, "_busy_last"}, 16'(ex_busy), 16'd0);
            tick();
            if (e <= DATA_W && (EXM_valid !== 1'b1 || EXM_Reg_write !== 1'b0)) bub_bad++;
        end
        chk({tag, "_busy_cycles"}, 16'(busy_n), 16'(DATA_W));
        chk({tag, "_bubbles"}, 16'(bub_bad), 16'd0);
        m_valid = 1'b0; m_res = exp_p; m_rd = EX_Reg_Rd; m_rw = EX_Reg_write;
        m_mr = EX_mem_read; m_mw = EX_mem_write; m_sd = EX_rt_data; m_known = 1;
        check_exm(tag);
        EX_valid = 1'b1;
    endtask

    initial begin
        logic [DATA_W-1:0] a, b, exp_p;
        logic [3:0] op;
        logic [1:0] fa, fb;
        int r, done_e;
        bit bub, fl, st;

        rst_n = 1'b1; stall_in = 1'b0; flush = 1'b0; MWB_wb_data = '0;
        drive(1'b1, 4'd0, 16'd0, 16'd0, 16'd0, 1'b0, 2'b00, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #10;
        chk("rst_valid", 16'(EXM_valid), 16'd1);
        chk("rst_rd", 16'(EXM_Reg_Rd), 16'd0);
        chk("rst_rw", 16'(EXM_Reg_write), 16'd0);
        chk("rst_mr", 16'(EXM_mem_read), 16'd0);
        chk("rst_mw", 16'(EXM_mem_write), 16'd0);
        chk("rst_res", EXM_alu_result, 16'd0);
        chk("rst_sd", EXM_store_data, 16'd0);
        chk("rst_busy", 16'(ex_busy), 16'd0);
        m_valid = 1'b1; m_rw = 0; m_mr = 0; m_mw = 0; m_rd = 0; m_res = 0; m_sd = 0; m_known = 1;
        @(negedge clk) rst_n = 1'b1;

        // ADD with immediate
        drive(1'b0, ALU_ADD, 16'd5, 16'd0, 16'd7, 1'b1, 2'b00, 2'b00, 3'd3, 1'b1, 1'b0, 1'b0);
        model_edge(); tick();
        chk("add_res", EXM_alu_result, 16'd12);
        chk("add_rd", 16'(EXM_Reg_Rd), 16'd3);
        chk("add_valid", 16'(EXM_valid), 16'd0);
        chk("add_rw", 16'(EXM_Reg_write), 16'd1);

        // EXM-forwarded SUB, then MWB-forwarded AND
        drive(1'b0, ALU_ADD, 16'd15, 16'd5, 16'd0, 1'b0, 2'b00, 2'b00, 3'd1, 1'b1, 1'b0, 1'b0);
        model_edge(); tick();
        chk("pre_sub", EXM_alu_result, 16'd20);
        drive(1'b0, ALU_SUB, 16'd999, 16'd4, 16'd0, 1'b0, 2'b01, 2'b00, 3'd2, 1'b1, 1'b0, 1'b0);
        model_edge(); tick();
        chk("sub_fwd_exm", EXM_alu_result, 16'd16);
        MWB_wb_data = 16'h00FF;
        drive(1'b0, ALU_AND, 16'h0F0F, 16'h1234, 16'd0, 1'b0, 2'b00, 2'b10, 3'd4, 1'b1, 1'b0, 1'b1);
        model_edge(); tick();
        chk("and_fwd_mwb", EXM_alu_result, 16'h000F);
        chk("and_store", EXM_store_data, 16'h00FF);
        chk("and_mw", 16'(EXM_mem_write), 16'd1);

        // MUL 300*300
        drive(1'b0, ALU_MUL, 16'd300, 16'd300, 16'd0, 1'b0, 2'b00, 2'b00, 3'd5, 1'b1, 1'b0, 1'b0);
        mul_seq("mul300", 16'h5F90, 1'b0);
        chk("mul300_const", EXM_alu_result, 16'h5F90);

        // Flush mid-multiply
        drive(1'b0, ALU_MUL, 16'd300, 16'd7, 16'd0, 1'b0, 2'b00, 2'b00, 3'd6, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        chk("flush_busy_before", 16'(ex_busy), 16'd1);
        flush = 1'b1;
        model_edge(); tick();
        flush = 1'b0;
        EX_valid = 1'b1;
        #1;
        chk("flush_busy_after", 16'(ex_busy), 16'd0);
        chk("flush_valid", 16'(EXM_valid), 16'd1);
        chk("flush_rw", 16'(EXM_Reg_write), 16'd0);
        drive(1'b0, ALU_ADD, 16'd1, 16'd2, 16'd0, 1'b0, 2'b00, 2'b00, 3'd2, 1'b1, 1'b0, 1'b0);
        model_edge(); tick();
        chk("post_flush_add", EXM_alu_result, 16'd3);
        chk("post_flush_valid", 16'(EXM_valid), 16'd0);

        // Stall for 3 cycles during RUN
        drive(1'b0, ALU_MUL, 16'd1234, 16'd56, 16'd0, 1'b0, 2'b00, 2'b00, 3'd6, 1'b1, 1'b0, 1'b0);
        done_e = -1;
        for (int e = 1; e <= 40; e++) begin
            stall_in = (e >= 5 && e <= 7);
            tick();
            if (EXM_valid === 1'b0) begin
                done_e = e;
                break;
            end
        end
        stall_in = 1'b0;
        chk("stall_mul_edges", 16'(done_e), 16'd20);
        chk("stall_mul_res", EXM_alu_result, 16'h0DF0);
        m_valid = 0; m_res = 16'h0DF0; m_rd = 3'd6; m_rw = 1; m_mr = 0; m_mw = 0; m_sd = 16'd56; m_known = 1;
        drive(1'b0, ALU_ADD, 16'd1, 16'd0, 16'd1, 1'b1, 2'b00, 2'b00, 3'd7, 1'b1, 1'b0, 1'b0);
        stall_in = 1'b1;
        model_edge(); tick();
        check_exm("stall_hold");
        stall_in = 1'b0;
        model_edge(); tick();
        check_exm("stall_release");
        flush = 1'b1; stall_in = 1'b1;
        model_edge(); tick();
        check_exm("flush_and_stall");
        flush = 1'b0; stall_in = 1'b0;

        // Reset mid-multiply
        drive(1'b0, ALU_MUL, 16'd300, 16'd300, 16'd0, 1'b0, 2'b00, 2'b00, 3'd5, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        #2;
        rst_n = 1'b0;
        EX_valid = 1'b1;
        #1;
        chk("rrst_valid", 16'(EXM_valid), 16'd1);
        chk("rrst_res", EXM_alu_result, 16'd0);
        chk("rrst_rd", 16'(EXM_Reg_Rd), 16'd0);
        chk("rrst_rw", 16'(EXM_Reg_write), 16'd0);
        chk("rrst_busy", 16'(ex_busy), 16'd0);
        m_valid = 1'b1; m_rw = 0; m_mr = 0; m_mw = 0; m_rd = 0; m_res = 0; m_sd = 0; m_known = 1;
        @(negedge clk) rst_n = 1'b1;
        drive(1'b0, ALU_SLT, 16'hFFFF, 16'd1, 16'd0, 1'b0, 2'b00, 2'b00, 3'd1, 1'b1, 1'b0, 1'b0);
        model_edge(); tick();
        chk("slt_after_reset", EXM_alu_result, 16'd1);

        // Random instruction stream
        for (int i = 0; i < 300; i++) begin
            r  = $urandom_range(0, 99);
            op = 4'($urandom_range(0, 15));
            fa = 2'($urandom_range(0, 3));
            fb = 2'($urandom_range(0, 3));
            if (!m_known && fa == 2'b01) fa = 2'b00;
            if (!m_known && fb == 2'b01) fb = 2'b00;
            bub = (r < 15); fl = (r >= 15 && r < 20); st = (r >= 20 && r < 25);
            MWB_wb_data = 16'($urandom);
            if (op == ALU_MUL && !bub && !fl && !st) begin
                drive(1'b0, op, 16'($urandom), 16'($urandom), 16'($urandom), 1'b0, fa, 2'b00,
                      3'($urandom), 1'($urandom), 1'b0, 1'b0);
                a = fwd_ref(fa, EX_rs_data);
                b = EX_rt_data;
                exp_p = alu_ref(8, int'(a), int'(b));
                mul_seq("rnd_mul", exp_p, 1'b1);
            end else begin
                if (op == ALU_MUL) op = ALU_XOR;
                drive(bub, op, 16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), fa, fb,
                      3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
                stall_in = st; flush = fl;
                #1;
                chk("rnd_busy", 16'(ex_busy), 16'd0);
                model_edge(); tick();
                check_exm("rnd");
                stall_in = 1'b0; flush = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
